// File: rtl/ws2801_pkg.sv
// rtl/ws2801_pkg.sv - shared WS2801 pixel types, receiver states and latch timing helper
package ws2801_pkg;

    localparam int PIXEL_W = 24;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RECV   = 2'd1,
        COMMIT = 2'd2
    } rx_state_t;

    // Clock cycles covering the 500 us latch time, rounded up.
    function automatic int latch_cycles(input longint freq);
        return int'((freq * 64'd500 + 64'd999_999) / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer with rising-edge detector
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic sync,
    output logic rise
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;

endmodule

// File: rtl/ws2801_receiver.sv
// rtl/ws2801_receiver.sv - WS2801 serial capture, reassembles latched frames into led_rgb
module ws2801_receiver
    import ws2801_pkg::*;
#(
    parameter int LEDS         = 50,
    parameter int LATCH_CYCLES = latch_cycles(781250),
    parameter int CNT_W        = $clog2(LATCH_CYCLES + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sci,
    input  logic                         sdi,
    output logic [24*LEDS-1:0]           led_rgb,
    output logic                         frame_valid,
    output logic [$clog2(LEDS+1)-1:0]    pixels_rx,
    output logic                         overflow,
    output logic                         partial,
    output logic                         busy
);

    localparam int PIX_W = $clog2(LEDS + 1);
    localparam int IDX_W = $clog2(PIXEL_W * LEDS);

    logic sci_sync;
    logic sci_rise;
    logic sdi_meta;
    logic sdi_sync;

    rx_state_t           state;
    logic [CNT_W-1:0]    idle_cnt;
    logic [4:0]          bit_cnt;
    logic [PIX_W-1:0]    pix_cnt;
    logic                ovf_flag;
    logic                pending;
    logic                pend_bit;
    logic [24*LEDS-1:0]  shadow;

    logic                latch_hit;
    logic                start;
    logic                do_shift;
    logic                shift_bit;
    logic [4:0]          cur_bit;
    logic [PIX_W-1:0]    cur_pix;
    logic                cur_ovf;
    logic                pix_full;
    logic                wrap;
    logic [IDX_W-1:0]    wr_idx;

    sync_edge_det u_sci_sync (
        .clk  (clk),
        .rst  (rst),
        .d    (sci),
        .sync (sci_sync),
        .rise (sci_rise)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sdi_meta <= 1'b0;
            sdi_sync <= 1'b0;
        end else begin
            sdi_meta <= sdi;
            sdi_sync <= sdi_meta;
        end
    end

    // An edge that coincides with the latch, or lands in COMMIT, is parked in
    // pending/pend_bit and becomes the first bit of the next frame.
    always_comb begin
        latch_hit = (idle_cnt == CNT_W'(LATCH_CYCLES));
        start     = (state == IDLE) && (sci_rise || pending);
        do_shift  = start || ((state == RECV) && sci_rise && !latch_hit);
        shift_bit = ((state == IDLE) && !sci_rise) ? pend_bit : sdi_sync;
        cur_bit   = start ? 5'd0 : bit_cnt;
        cur_pix   = start ? '0 : pix_cnt;
        cur_ovf   = start ? 1'b0 : ovf_flag;
        pix_full  = (cur_pix == PIX_W'(LEDS));
        wrap      = (cur_bit == 5'd23);
        wr_idx    = IDX_W'(cur_pix) * IDX_W'(PIXEL_W) + IDX_W'(PIXEL_W - 1) - IDX_W'(cur_bit);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            idle_cnt    <= '0;
            bit_cnt     <= '0;
            pix_cnt     <= '0;
            ovf_flag    <= 1'b0;
            pending     <= 1'b0;
            pend_bit    <= 1'b0;
            shadow      <= '0;
            led_rgb     <= '0;
            frame_valid <= 1'b0;
            pixels_rx   <= '0;
            overflow    <= 1'b0;
            partial     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;

            if (sci_sync) begin
                idle_cnt <= '0;
            end else if (!latch_hit) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (do_shift) begin
                if (!pix_full) begin
                    shadow[wr_idx] <= shift_bit;
                end
                bit_cnt  <= wrap ? 5'd0 : cur_bit + 5'd1;
                pix_cnt  <= (wrap && !pix_full) ? cur_pix + 1'b1 : cur_pix;
                ovf_flag <= cur_ovf | (wrap && pix_full);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RECV;
                        pending <= 1'b0;
                    end
                end
                RECV: begin
                    if (latch_hit) begin
                        state    <= COMMIT;
                        pending  <= sci_rise;
                        pend_bit <= sdi_sync;
                    end
                end
                COMMIT: begin
                    led_rgb     <= shadow;
                    pixels_rx   <= pix_cnt;
                    overflow    <= ovf_flag;
                    partial     <= (bit_cnt != 5'd0);
                    frame_valid <= 1'b1;
                    state       <= IDLE;
                    if (sci_rise) begin
                        pending  <= 1'b1;
                        pend_bit <= sdi_sync;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RECV);

endmodule

// File: tb/tb_ws2801_receiver.sv
// tb/tb_ws2801_receiver.sv - scoreboard bench for ws2801_receiver driven by an emulated driver
module tb_ws2801_receiver;
    import ws2801_pkg::*;

    localparam int LEDS  = 3;
    localparam int LATCH = 40;
    localparam int HALF  = 4;
    localparam int PW    = $clog2(LEDS + 1);

    logic clk = 1'b0;
    logic rst;
    logic sci;
    logic sdi;
    logic [24*LEDS-1:0] led_rgb;
    logic               frame_valid;
    logic [PW-1:0]      pixels_rx;
    logic               overflow;
    logic               partial;
    logic               busy;

    always #5 clk = ~clk;

    ws2801_receiver #(
        .LEDS         (LEDS),
        .LATCH_CYCLES (LATCH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sci         (sci),
        .sdi         (sdi),
        .led_rgb     (led_rgb),
        .frame_valid (frame_valid),
        .pixels_rx   (pixels_rx),
        .overflow    (overflow),
        .partial     (partial),
        .busy        (busy)
    );

    typedef struct {
        logic [24*LEDS-1:0] led;
        int                 pix;
        logic               ovf;
        logic               part;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   total   = 0;
    int   bad     = 0;
    int   commits = 0;
    logic fv_prev = 1'b0;

    logic [24*LEDS-1:0] model;
    logic               bits[$];

    // Commit monitor: pops the scoreboard on every frame_valid pulse.
    always @(negedge clk) begin
        if (frame_valid) begin
            commits++;
            total++;
            if (fv_prev) begin
                bad++;
                $display("FAIL fv_width: frame_valid high two cycles in a row, required one");
            end
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_commit: led_rgb=%h with no frame expected", led_rgb);
            end else begin
                cur = sb.pop_front();
                if (led_rgb !== cur.led || pixels_rx !== PW'(cur.pix) ||
                    overflow !== cur.ovf || partial !== cur.part) begin
                    bad++;
                    $display("FAIL commit: got led=%h pix=%0d ovf=%b part=%b want led=%h pix=%0d ovf=%b part=%b",
                             led_rgb, pixels_rx, overflow, partial, cur.led, cur.pix, cur.ovf, cur.part);
                end
            end
        end
        fv_prev = frame_valid;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic add_pixel(input pixel_t p);
        for (int i = 23; i >= 0; i--) bits.push_back(p[i]);
    endtask

    task automatic model_frame();
        int   m_pix = 0;
        int   m_bit = 0;
        logic m_ovf = 1'b0;
        exp_t e;
        foreach (bits[i]) begin
            if (m_pix < LEDS) model[24*m_pix + 23 - m_bit] = bits[i];
            m_bit++;
            if (m_bit == 24) begin
                m_bit = 0;
                if (m_pix == LEDS) m_ovf = 1'b1;
                else m_pix++;
            end
        end
        e.led  = model;
        e.pix  = m_pix;
        e.ovf  = m_ovf;
        e.part = (m_bit != 0);
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b, input int low);
        sdi = b;
        sci = 1'b0;
        repeat (low) @(negedge clk);
        sci = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_bits(input int gap_at, input int gap_len);
        foreach (bits[i]) send_bit(bits[i], (i == gap_at) ? gap_len : HALF);
    endtask

    task automatic end_frame();
        sci = 1'b0;
        repeat (LATCH + 10) @(negedge clk);
    endtask

    task automatic wait_commits(input int target, input int budget);
        int n = 0;
        while (commits < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (commits != target) begin
            bad++;
            $display("FAIL commit_count: got %0d commits, want %0d", commits, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        sci = 1'b0;
        sdi = 1'b0;
        model = '0;
        repeat (3) @(negedge clk);
        total++;
        if (led_rgb !== '0 || pixels_rx !== '0 || overflow !== 1'b0 || partial !== 1'b0) begin
            bad++;
            $display("FAIL reset_status: led=%h pix=%0d ovf=%b part=%b want all zero",
                     led_rgb, pixels_rx, overflow, partial);
        end
        total++;
        if (frame_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags: fv=%b busy=%b want 0 0", frame_valid, busy);
        end
        rst = 1'b1;
        repeat (LATCH + 10) @(negedge clk);
        total++;
        if (commits != 0) begin
            bad++;
            $display("FAIL idle_no_commit: got %0d commits while idle, want 0", commits);
        end
    endtask

    task automatic test_loopback();
        logic [71:0] drv = 72'hFF0000_00FF00_0000FF;
        int c0 = commits;
        bits.delete();
        for (int k = 0; k < LEDS; k++) add_pixel(drv[24*k +: 24]);
        model_frame();
        send_bits(-1, 0);
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL busy_recv: got %b want 1", busy);
        end
        end_frame();
        wait_commits(c0 + 1, 200);
        total++;
        if (led_rgb !== drv || pixels_rx !== PW'(3) || overflow !== 1'b0 || partial !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL loopback: got led=%h pix=%0d ovf=%b part=%b busy=%b want %h 3 0 0 0",
                     led_rgb, pixels_rx, overflow, partial, busy, drv);
        end
    endtask

    task automatic test_overflow();
        int c0 = commits;
        bits.delete();
        add_pixel(24'h112233);
        add_pixel(24'h445566);
        add_pixel(24'h778899);
        add_pixel(24'hABCDEF);
        model_frame();
        send_bits(-1, 0);
        end_frame();
        wait_commits(c0 + 1, 200);
        total++;
        if (pixels_rx !== PW'(3) || overflow !== 1'b1 || led_rgb[23:0] !== 24'h112233) begin
            bad++;
            $display("FAIL overflow: got pix=%0d ovf=%b px0=%h want 3 1 112233",
                     pixels_rx, overflow, led_rgb[23:0]);
        end
        for (int k = 0; k < LEDS; k++) begin
            total++;
            if (led_rgb[24*k +: 24] === 24'hABCDEF) begin
                bad++;
                $display("FAIL overflow_wrap: pixel %0d got %h, must not hold abcdef", k, led_rgb[24*k +: 24]);
            end
        end
    endtask

    task automatic test_partial();
        logic [5:0] tail = 6'b101101;
        int c0 = commits;
        bits.delete();
        add_pixel(24'h5A5A5A);
        for (int i = 5; i >= 0; i--) bits.push_back(tail[i]);
        model_frame();
        send_bits(-1, 0);
        end_frame();
        wait_commits(c0 + 1, 200);
        total++;
        if (partial !== 1'b1 || pixels_rx !== PW'(1) || overflow !== 1'b0 || led_rgb[23:0] !== 24'h5A5A5A) begin
            bad++;
            $display("FAIL partial: got part=%b pix=%0d ovf=%b px0=%h want 1 1 0 5a5a5a",
                     partial, pixels_rx, overflow, led_rgb[23:0]);
        end
    endtask

    task automatic test_near_latch_gap();
        int c0 = commits;
        bits.delete();
        add_pixel(24'h0F0F0F);
        add_pixel(24'hF0F0F0);
        model_frame();
        send_bits(20, LATCH - 1);
        total++;
        if (commits != c0) begin
            bad++;
            $display("FAIL gap_early_commit: got %0d commits, want %0d", commits, c0);
        end
        end_frame();
        wait_commits(c0 + 1, 200);
        total++;
        if (pixels_rx !== PW'(2) || led_rgb[47:0] !== 48'hF0F0F0_0F0F0F) begin
            bad++;
            $display("FAIL gap_frame: got pix=%0d px=%h want 2 f0f0f00f0f0f", pixels_rx, led_rgb[47:0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int c0 = commits;
        bits.delete();
        add_pixel(24'h111111);
        add_pixel(24'h222222);
        repeat (8) void'(bits.pop_back());
        send_bits(-1, 0);
        rst = 1'b0;
        #1;
        total++;
        if (led_rgb !== '0 || pixels_rx !== '0 || overflow !== 1'b0 || partial !== 1'b0 ||
            frame_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got led=%h pix=%0d ovf=%b part=%b fv=%b busy=%b want all zero",
                     led_rgb, pixels_rx, overflow, partial, frame_valid, busy);
        end
        sci = 1'b0;
        model = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (LATCH + 20) @(negedge clk);
        total++;
        if (commits != c0) begin
            bad++;
            $display("FAIL reset_discard: got %0d commits, want %0d", commits, c0);
        end
        bits.delete();
        add_pixel(24'hC0FFEE);
        add_pixel(24'h0A0B0C);
        add_pixel(24'h7E7E7E);
        model_frame();
        send_bits(-1, 0);
        end_frame();
        wait_commits(c0 + 1, 200);
        total++;
        if (led_rgb !== 72'h7E7E7E_0A0B0C_C0FFEE || pixels_rx !== PW'(3)) begin
            bad++;
            $display("FAIL after_reset: got led=%h pix=%0d want 7e7e7e0a0b0cc0ffee 3", led_rgb, pixels_rx);
        end
    endtask

    task automatic test_back_to_back();
        int c0 = commits;
        bits.delete();
        add_pixel(24'h123456);
        model_frame();
        send_bits(-1, 0);
        bits.delete();
        add_pixel(24'h654321);
        model_frame();
        send_bits(0, LATCH);
        end_frame();
        wait_commits(c0 + 2, 200);
        total++;
        if (led_rgb[23:0] !== 24'h654321 || pixels_rx !== PW'(1) || partial !== 1'b0) begin
            bad++;
            $display("FAIL back_to_back: got px0=%h pix=%0d part=%b want 654321 1 0",
                     led_rgb[23:0], pixels_rx, partial);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_overflow();
        test_partial();
        test_near_latch_gap();
        test_reset_mid_frame();
        test_back_to_back();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d expected frames never committed, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ws2801_receiver.md
Name: ws2801_receiver

Overview:
- Capture-side counterpart of the WS2801 LED driver. Samples the serial clock/data pair the driver emits (clock out, data out) and reassembles complete frames into the same packed `led_rgb` layout.
- A frame ends on the WS2801 latch condition, meaning the serial clock is held low long enough.
- Used for on-board loopback: one GPIO pair drives back into another. Also used as the bench monitor for driver verification.

Parameters:
- LEDS, 50, number of 24-bit pixels per frame; sets the `led_rgb` width.
- LATCH_CYCLES, 391, consecutive `clk` cycles with `sci` low that end a frame. Default is 500 us at 781250 Hz.
- CNT_W, $clog2(LATCH_CYCLES+1), width of the idle counter.

Ports:
- clk  input  1  system clock; must be at least 4x the `sci` toggle rate.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- sci  input  1  serial clock from the driver; asynchronous to `clk`.
- sdi  input  1  serial data from the driver; asynchronous to `clk`.
- led_rgb  output  24*LEDS  last committed frame; pixel k at `[24k +: 24]`.
- frame_valid  output  1  one-cycle pulse when `led_rgb` is updated.
- pixels_rx  output  $clog2(LEDS+1)  whole pixels in the last frame, saturating at LEDS.
- overflow  output  1  last frame carried more than LEDS pixels.
- partial  output  1  last frame ended with a bit count that is not a multiple of 24.
- busy  output  1  FSM is in RECV.

Behaviour:
- Reset (rst=0, asynchronous): all outputs are 0, synchronizers are 0, FSM goes to IDLE.
- Reset mid-frame discards the shadow buffer. No frame_valid is produced for that frame.
- Input sync: `sci` and `sdi` each pass through a 2-flop synchronizer. A rising edge is detected as sync=1 and previous=0.
- `sdi` is sampled from the synchronized value in the same cycle the `sci` edge is detected. Latency from the input edge to the shift is 3 `clk` cycles.
- Bit order: MSB-first within each pixel. The first bit of pixel k lands in shadow bit 24k+23. Pixel 0 is the first pixel received.
- Counters: `bit_cnt` runs 0..23 and `pix_cnt` runs 0..LEDS.
- When `bit_cnt` wraps from 23 to 0, `pix_cnt` increments, saturating at LEDS, and `ovf_flag` sets if `pix_cnt` was already LEDS.
- Bits beyond LEDS pixels are discarded. They do not wrap into pixel 0.
- Idle counter: cleared whenever synchronized `sci` = 1. Otherwise it increments, saturating at LATCH_CYCLES.
- FSM IDLE:
  - waits for a `sci` rising edge;
  - on the edge, clears `bit_cnt`, `pix_cnt` and `ovf_flag`, then shifts that first bit and moves to RECV;
  - the shadow buffer is not cleared, so unreceived pixels keep stale shadow contents.
- FSM RECV:
  - shifts on each rising edge;
  - when the idle counter reaches LATCH_CYCLES, goes to COMMIT.
- FSM COMMIT (one cycle):
  - `led_rgb` <= shadow;
  - `pixels_rx` <= `pix_cnt`;
  - `overflow` <= `ovf_flag`;
  - `partial` <= (`bit_cnt` != 0);
  - `frame_valid` = 1;
  - next state is IDLE.
- A `sci` edge arriving during COMMIT is held and processed in IDLE the next cycle; no bit is lost.
- Latch only matters in RECV. Long idle periods in IDLE never pulse `frame_valid`.
- A frame of zero complete bits cannot commit, because entry to RECV requires at least one edge.
- Status outputs hold until the next COMMIT. `frame_valid` is high for exactly one cycle per commit.

Decomposition:
- Package `ws2801_pkg`:
  - `PIXEL_W=24`;
  - typedef `pixel_t` (logic [23:0]);
  - enum `rx_state_t {IDLE, RECV, COMMIT}`;
  - function `latch_cycles(freq)` returning ceil(500e-6*freq).
- The LED driver should adopt the same package.
- One sub-module, `sync_edge_det`: 2-flop synchronizer plus rising-edge detector, used for `sci`. `sdi` uses the synchronizer path only.

Test Plan:
- Loopback with the LED driver at LEDS=3, driver input 0xFF0000_00FF00_0000FF -> one frame_valid; `led_rgb` equals the driver input; pixels_rx=3; overflow=0; partial=0.
- 4 pixels sent with LEDS=3, 4th pixel 0xABCDEF -> pixels_rx=3; overflow=1; pixel 0 unchanged; 0xABCDEF appears nowhere.
- 30 bits then latch -> partial=1; pixels_rx=1; pixel 0 correct.
- `sci` low for LATCH_CYCLES-1 cycles mid-frame, then more bits -> no commit; the frame continues and commits once, after the true latch.
- rst=0 asserted after 40 bits of a frame -> all outputs are 0 immediately (asynchronous) and no frame_valid follows. The next full frame is captured correctly.
- Two back-to-back frames 0x123456 then 0x654321 (LEDS=1) -> two frame_valid pulses, each exactly 1 cycle; `led_rgb` shows 0x123456, then 0x654321.
